// File: rtl/divisor_secuencial.sv
// -----------------------------------------------------------------------------
// divisor_secuencial
// Sequential restoring divider, one quotient bit per clock, with a one-hot
// controller (INICIO -> VERIF -> ITERA x ANCHO -> AJUSTE -> FIN).
//
// Parameters
//   ANCHO      operand/result width (4..32)
//   CON_SIGNO  0 = unsigned, 1 = two's-complement signed (truncating)
// Ports
//   reloj        clock, rising edge
//   reset        synchronous, active-high
//   go           level start request in INICIO / hold request in FIN
//   dividendo    dividend, sampled on the start edge
//   divisor      divisor, sampled on the start edge
//   cociente     registered quotient
//   residuo      registered remainder
//   listo        high in INICIO
//   hecho        high in FIN
//   div_cero     result came from a zero divisor
//   desborde     signed overflow (most negative / -1)
//   Est          one-hot state vector
//   EstPresente  binary code of Est, observation only
// -----------------------------------------------------------------------------
module divisor_secuencial #(
    parameter int ANCHO     = 16,
    parameter bit CON_SIGNO = 1'b0
) (
    input  logic             reloj,
    input  logic             reset,
    input  logic             go,
    input  logic [ANCHO-1:0] dividendo,
    input  logic [ANCHO-1:0] divisor,
    output logic [ANCHO-1:0] cociente,
    output logic [ANCHO-1:0] residuo,
    output logic             listo,
    output logic             hecho,
    output logic             div_cero,
    output logic             desborde,
    output logic [4:0]       Est,
    output logic [2:0]       EstPresente
);

    // State codes double as bit positions in the one-hot vector.
    typedef enum logic [2:0] {
        INICIO = 3'd0,
        VERIF  = 3'd1,
        ITERA  = 3'd2,
        AJUSTE = 3'd3,
        FIN    = 3'd4
    } estado_t;

    localparam int CW = $clog2(ANCHO + 1);

    logic [4:0]       est_q, est_d;
    logic             one_hot;
    logic [CW-1:0]    cnt_q;
    logic [ANCHO-1:0] ddo_q;          // raw dividend, for the divide-by-zero result
    logic [ANCHO-1:0] quo_q;          // dividend magnitude shifting out, quotient shifting in
    logic [ANCHO-1:0] dsr_q;          // divisor magnitude
    logic [ANCHO-1:0] rem_q;          // partial remainder (always < divisor)
    logic             sgn_dd_q, sgn_ds_q;
    logic [ANCHO-1:0] coc_q, res_q;
    logic             div_cero_q, desborde_q;

    logic             s_dd, s_ds;
    logic [ANCHO-1:0] mag_dd, mag_ds;
    logic [ANCHO:0]   desp, resta;
    logic             en_inicio, en_verif, en_itera, en_ajuste, en_fin;

    assign one_hot   = (est_q != 5'd0) && ((est_q & (est_q - 5'd1)) == 5'd0);
    assign en_inicio = one_hot & est_q[INICIO];
    assign en_verif  = one_hot & est_q[VERIF];
    assign en_itera  = one_hot & est_q[ITERA];
    assign en_ajuste = one_hot & est_q[AJUSTE];
    assign en_fin    = one_hot & est_q[FIN];

    // ---------------- controller ----------------
    always_ff @(posedge reloj) begin
        if (reset) est_q <= 5'b00001;
        else       est_q <= est_d;
    end

    always_comb begin
        est_d = 5'd0;
        if (en_inicio) begin
            if (go) est_d[VERIF]  = 1'b1;
            else    est_d[INICIO] = 1'b1;
        end else if (en_verif) begin
            if (dsr_q == '0) est_d[FIN]   = 1'b1;
            else             est_d[ITERA] = 1'b1;
        end else if (en_itera) begin
            if (cnt_q == CW'(1)) est_d[AJUSTE] = 1'b1;
            else                 est_d[ITERA]  = 1'b1;
        end else if (en_ajuste) begin
            est_d[FIN] = 1'b1;
        end else if (en_fin) begin
            if (go) est_d[FIN]    = 1'b1;
            else    est_d[INICIO] = 1'b1;
        end else begin
            // Not one-hot: recover to INICIO.
            est_d[INICIO] = 1'b1;
        end
    end

    // ---------------- datapath ----------------
    assign s_dd   = CON_SIGNO & dividendo[ANCHO-1];
    assign s_ds   = CON_SIGNO & divisor[ANCHO-1];
    assign mag_dd = s_dd ? ({ANCHO{1'b0}} - dividendo) : dividendo;
    assign mag_ds = s_ds ? ({ANCHO{1'b0}} - divisor)   : divisor;

    // Restoring step: shift in next dividend bit, try subtracting the divisor;
    // the borrow bit decides whether to keep the difference.
    assign desp  = {rem_q, quo_q[ANCHO-1]};
    assign resta = desp - {1'b0, dsr_q};

    always_ff @(posedge reloj) begin
        if (reset) begin
            cnt_q      <= '0;
            ddo_q      <= '0;
            quo_q      <= '0;
            dsr_q      <= '0;
            rem_q      <= '0;
            sgn_dd_q   <= 1'b0;
            sgn_ds_q   <= 1'b0;
            coc_q      <= '0;
            res_q      <= '0;
            div_cero_q <= 1'b0;
            desborde_q <= 1'b0;
        end else begin
            if (en_inicio && go) begin
                ddo_q      <= dividendo;
                quo_q      <= mag_dd;
                dsr_q      <= mag_ds;
                sgn_dd_q   <= s_dd;
                sgn_ds_q   <= s_ds;
                rem_q      <= '0;
                cnt_q      <= CW'(ANCHO);
                div_cero_q <= 1'b0;
                desborde_q <= 1'b0;
            end
            if (en_verif && dsr_q == '0) begin
                coc_q      <= '1;
                res_q      <= ddo_q;
                div_cero_q <= 1'b1;
                desborde_q <= 1'b0;
            end
            if (en_itera) begin
                if (resta[ANCHO]) rem_q <= desp[ANCHO-1:0];
                else              rem_q <= resta[ANCHO-1:0];
                quo_q <= {quo_q[ANCHO-2:0], ~resta[ANCHO]};
                cnt_q <= cnt_q - CW'(1);
            end
            if (en_ajuste) begin
                coc_q <= (sgn_dd_q ^ sgn_ds_q) ? ({ANCHO{1'b0}} - quo_q) : quo_q;
                res_q <= sgn_dd_q ? ({ANCHO{1'b0}} - rem_q) : rem_q;
                // With equal signs a positive result can never reach 2^(ANCHO-1)
                // except for most-negative / -1, so the magnitude MSB flags it.
                desborde_q <= CON_SIGNO & ~(sgn_dd_q ^ sgn_ds_q) & quo_q[ANCHO-1];
            end
        end
    end

    assign cociente    = coc_q;
    assign residuo     = res_q;
    assign div_cero    = div_cero_q;
    assign desborde    = desborde_q;
    assign listo       = est_q[INICIO];
    assign hecho       = est_q[FIN];
    assign Est         = est_q;
    assign EstPresente = {est_q[4], est_q[3] | est_q[2], est_q[3] | est_q[1]};

endmodule

// File: doc/divisor_secuencial.md
DIVISOR_SECUENCIAL -- requirements
Module: divisor_secuencial

Interface
REQ-001 SHALL have parameter ANCHO, default 16, operand/result width in bits, legal range 4..32.
REQ-002 SHALL have parameter CON_SIGNO, default 0: 0 = unsigned division, 1 = two's-complement signed division.
REQ-003 SHALL have port reloj, input, 1 bit: the single clock; all state changes on its rising edge.
REQ-004 SHALL have port reset, input, 1 bit: synchronous, active-high reset.
REQ-005 SHALL have port go, input, 1 bit: level-sensitive start/acknowledge request.
REQ-006 SHALL have port dividendo, input, ANCHO bits: dividend, sampled only on the start edge.
REQ-007 SHALL have port divisor, input, ANCHO bits: divisor, sampled only on the start edge.
REQ-008 SHALL have port cociente, output, ANCHO bits: registered quotient.
REQ-009 SHALL have port residuo, output, ANCHO bits: registered remainder.
REQ-010 SHALL have port listo, output, 1 bit: high only in state INICIO.
REQ-011 SHALL have port hecho, output, 1 bit: high only in state FIN.
REQ-012 SHALL have port div_cero, output, 1 bit: divisor was zero for the current result.
REQ-013 SHALL have port desborde, output, 1 bit: signed overflow for the current result.
REQ-014 SHALL have port Est, output, 5 bits: one-hot state vector, one flip-flop per state.
REQ-015 SHALL have port EstPresente, output, 3 bits: binary code of the state, ORed from Est, for observation only.

Function
REQ-016 SHALL implement the controller as one-hot with states and codes INICIO=0, VERIF=1, ITERA=2, AJUSTE=3, FIN=4.
REQ-017 SHALL, in INICIO with go=1, latch the operand magnitudes and signs, load iteration counter = ANCHO, clear div_cero/desborde, and go to VERIF; with go=0 it SHALL remain in INICIO.
REQ-018 SHALL, in VERIF with divisor latch = 0, set div_cero=1, cociente=all ones, residuo=dividendo as latched (raw, unsigned), desborde=0, and go to FIN; otherwise it SHALL go to ITERA.
REQ-019 SHALL, in ITERA, perform one restoring shift-subtract step per cycle on magnitudes with an ANCHO+1-bit partial remainder, and decrement the counter.
REQ-020 SHALL leave ITERA for AJUSTE on the cycle that performs the step with counter = 1, giving exactly ANCHO steps.
REQ-021 SHALL, in AJUSTE, write cociente/residuo: unsigned = magnitudes; signed = quotient negated if operand signs differ, remainder carrying the dividend's sign (truncation toward zero); then go to FIN.
REQ-022 SHALL, when CON_SIGNO=1 and dividendo = -2^(ANCHO-1) and divisor = -1, give cociente = 0x..80..0 (wrapped), residuo = 0, and desborde = 1.
REQ-023 SHALL, in FIN, hold all outputs stable while go=1, and return to INICIO on the edge where go=0.
REQ-024 SHALL ignore go and operand inputs in VERIF, ITERA and AJUSTE; no abort exists.
REQ-025 SHALL keep cociente, residuo, div_cero and desborde unchanged outside VERIF (zero case) and AJUSTE, so results persist through INICIO until the next operation.
REQ-026 SHALL give latency, counted in rising edges from the go-sampling edge in INICIO to hecho=1: ANCHO+2 for a normal division, 1 for divide-by-zero.
REQ-027 SHALL force INICIO on the next edge from any Est value that is not one-hot.

Reset
REQ-028 SHALL, on a reloj edge with reset=1, set Est=00001 (INICIO) from any state, including mid-ITERA.
REQ-029 SHALL, on reset, clear cociente, residuo, div_cero, desborde and the counter, giving listo=1 and hecho=0.
REQ-030 SHALL give reset priority over go on the same edge.

Verification (ANCHO=16)
REQ-031 SHALL cover CON_SIGNO=0, 100/7 -> cociente=14, residuo=2, hecho 18 edges after start; Est walks 1,2,4(x16),8,16.
REQ-032 SHALL cover 1234/0 -> div_cero=1, cociente=0xFFFF, residuo=1234, hecho 1 edge after start, ITERA never entered.
REQ-033 SHALL cover CON_SIGNO=1, -7/2 -> cociente=0xFFFD, residuo=0xFFFF; and 0x8000/0xFFFF -> cociente=0x8000, residuo=0, desborde=1.
REQ-034 SHALL cover go held high 10 cycles in FIN -> outputs frozen, then go=0 -> INICIO next edge; go=1 the following edge -> new operation starts and flags clear.
REQ-035 SHALL cover reset asserted on the 5th ITERA cycle -> Est=00001, all outputs 0 next edge, and a following 100/7 computes correctly.
REQ-036 SHALL check, every cycle, that Est is one-hot and EstPresente equals its binary code.
